// File: rtl/x_iddr_pkg.sv
// x_iddr_pkg: shared constants and sizing helpers for the DDR input deserializer.
// Rev 1.0
`default_nettype none

package x_iddr_pkg;

  // Cycles during which further bitslip requests are dropped after an accepted one.
  localparam int LOCKOUT_LEN = 2;

  function automatic int pair_count(input int width);
    return width / 2;
  endfunction

  function automatic int cnt_width(input int width);
    return (width / 2 <= 2) ? 1 : $clog2(width / 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/x_iddr_cap.sv
// x_iddr_cap: dual-edge capture of D and realignment of both samples onto C0.
// Rev 1.0
`default_nettype none

module x_iddr_cap
  import x_iddr_pkg::*;
#(
  parameter logic INIT_Q0 = 1'b0,
  parameter logic INIT_Q1 = 1'b0
) (
  input  logic C0,
  input  logic C1,
  input  logic CLR,
  input  logic CE,
  input  logic D,
  output logic Q0,
  output logic Q1
);

  logic r0_q;
  logic r1_q;
  logic q0_q;
  logic q1_q;

  always_ff @(posedge C1 or posedge CLR) begin
    if (CLR) begin
      r1_q <= INIT_Q1;
    end else if (CE) begin
      r1_q <= D;
    end
  end

  // r1 only has to settle before the next C0 edge, where it joins r0 as a pair.
  always_ff @(posedge C0 or posedge CLR) begin
    if (CLR) begin
      r0_q <= INIT_Q0;
      q0_q <= INIT_Q0;
      q1_q <= INIT_Q1;
    end else if (CE) begin
      r0_q <= D;
      q0_q <= r0_q;
      q1_q <= r1_q;
    end
  end

  assign Q0 = q0_q;
  assign Q1 = q1_q;

endmodule

`default_nettype wire

// File: rtl/x_iddr_deser.sv
// x_iddr_deser: DDR input capture feeding a WIDTH-bit gearbox with bitslip alignment.
// Rev 1.0
`default_nettype none

module x_iddr_deser
  import x_iddr_pkg::*;
#(
  parameter logic INIT_Q0 = 1'b0,
  parameter logic INIT_Q1 = 1'b0,
  parameter int   WIDTH   = 8
) (
  input  logic             C0,
  input  logic             C1,
  input  logic             CLR,
  input  logic             CE,
  input  logic             D,
  input  logic             BITSLIP,
  output logic             Q0,
  output logic             Q1,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID
);

  localparam int            PAIRS    = pair_count(WIDTH);
  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(PAIRS - 1);
  localparam logic [1:0]    LOCK_SET = 2'(LOCKOUT_LEN);

  logic             w_q0;
  logic             w_q1;

  logic [WIDTH:0]   sr_q,     sr_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             ofs_q,    ofs_d;
  logic [1:0]       lock_q,   lock_d;
  logic [WIDTH-1:0] dout_q,   dout_d;
  logic             dvalid_q, dvalid_d;

  logic             w_accept;
  logic             w_hold;
  logic             w_emit;

  x_iddr_cap #(
    .INIT_Q0 (INIT_Q0),
    .INIT_Q1 (INIT_Q1)
  ) u_cap (
    .C0  (C0),
    .C1  (C1),
    .CLR (CLR),
    .CE  (CE),
    .D   (D),
    .Q0  (w_q0),
    .Q1  (w_q1)
  );

  // Clearing ofs costs one pair of shift with no count, which nets the same
  // +1 bit boundary move as setting it.
  always_comb begin
    sr_d     = {sr_q[WIDTH-2:0], w_q0, w_q1};
    w_accept = BITSLIP && (lock_q == 2'd0);
    w_hold   = w_accept && ofs_q;
    w_emit   = (cnt_q == CNT_LAST) && !w_hold;

    cnt_d = cnt_q;
    if (!w_hold) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    ofs_d  = w_accept ? ~ofs_q : ofs_q;

    lock_d = lock_q;
    if (w_accept) begin
      lock_d = LOCK_SET;
    end else if (lock_q != 2'd0) begin
      lock_d = lock_q - 2'd1;
    end

    dout_d = dout_q;
    if (w_emit) begin
      dout_d = ofs_q ? sr_d[WIDTH:1] : sr_d[WIDTH-1:0];
    end
    dvalid_d = w_emit;
  end

  always_ff @(posedge C0 or posedge CLR) begin
    if (CLR) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      ofs_q    <= 1'b0;
      lock_q   <= 2'd0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      // The strobe must drop while the block is stalled, so it is not held.
      dvalid_q <= CE && dvalid_d;
      if (CE) begin
        sr_q   <= sr_d;
        cnt_q  <= cnt_d;
        ofs_q  <= ofs_d;
        lock_q <= lock_d;
        dout_q <= dout_d;
      end
    end
  end

  assign Q0     = w_q0;
  assign Q1     = w_q1;
  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_x_iddr_deser.sv
// tb_x_iddr_deser: directed self-checking bench for x_iddr_deser (WIDTH=8).
// Rev 1.0
`default_nettype none

module tb_x_iddr_deser;

  logic       c0 = 1'b0;
  logic       c1;
  logic       clr;
  logic       ce;
  logic       d;
  logic       bitslip;

  logic       q0_a, q1_a, dv_a;
  logic [7:0] dout_a;
  logic       q0_b, q1_b, dv_b;
  logic [7:0] dout_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 c0 = ~c0;
  assign c1 = ~c0;

  x_iddr_deser #(.INIT_Q0(1'b1), .INIT_Q1(1'b0), .WIDTH(8)) dut_a (
    .C0(c0), .C1(c1), .CLR(clr), .CE(ce), .D(d), .BITSLIP(bitslip),
    .Q0(q0_a), .Q1(q1_a), .DOUT(dout_a), .DVALID(dv_a)
  );

  x_iddr_deser #(.INIT_Q0(1'b0), .INIT_Q1(1'b0), .WIDTH(8)) dut_b (
    .C0(c0), .C1(c1), .CLR(clr), .CE(ce), .D(d), .BITSLIP(bitslip),
    .Q0(q0_b), .Q1(q1_b), .DOUT(dout_b), .DVALID(dv_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // d0 is sampled at the next C0 edge, d1 at the C1 edge that follows it.
  task automatic step(input logic d0, input logic d1);
    d = d0;
    @(posedge c0);
    #1;
    d = d1;
    @(posedge c1);
    #1;
  endtask

  initial begin
    clr = 1'b1; ce = 1'b0; d = 1'b0; bitslip = 1'b0;
    repeat (2) @(posedge c1);
    #1;
    check("rst_q0_a",   16'(q0_a),   16'h1);
    check("rst_q1_a",   16'(q1_a),   16'h0);
    check("rst_dout_a", 16'(dout_a), 16'h0);
    check("rst_dv_a",   16'(dv_a),   16'h0);

    // Constant 1s: first word carries the two INIT pairs.
    clr = 1'b0; ce = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1);
      check("ones_dv", 16'(dv_b), 16'(k == 4 || k == 8));
      if (k == 4) begin
        check("ones_first_b", 16'(dout_b), 16'h0F);
        check("ones_first_a", 16'(dout_a), 16'hAF);
      end
      if (k == 8) check("ones_second_b", 16'(dout_b), 16'hFF);
    end

    // Alternating stream: 1 at C0, 0 at C1.
    for (int k = 9; k <= 20; k++) begin
      step(1'b1, 1'b0);
      check("aa_dv", 16'(dv_b), 16'(k % 4 == 0));
      if (k % 4 == 0) check("aa_word", 16'(dout_b), (k == 12) ? 16'hFA : 16'hAA);
      if (k == 10) begin
        check("aa_q0", 16'(q0_b), 16'h1);
        check("aa_q1", 16'(q1_b), 16'h0);
      end
    end

    // Slip at 22 (ofs 0->1), slip at 25 (ofs 1->0, hold), request at 26 inside lockout.
    for (int k = 21; k <= 36; k++) begin
      bitslip = (k == 22 || k == 25 || k == 26);
      step(1'b1, 1'b0);
      bitslip = 1'b0;
      check("slip_dv", 16'(dv_b), 16'(k == 24 || k == 29 || k == 33));
      if (k == 24) check("slip_w55", 16'(dout_b), 16'h55);
      if (k == 29) check("slip_wAA", 16'(dout_b), 16'hAA);
      if (k == 33) check("slip_wAA2", 16'(dout_b), 16'hAA);
    end

    // Stall mid-word; garbage data and a slip request during the stall must be ignored.
    step(1'b1, 1'b0);
    check("ce_pre_dv", 16'(dv_b), 16'h1);
    step(1'b1, 1'b0);
    for (int k = 39; k <= 41; k++) begin
      ce = 1'b0;
      bitslip = (k == 40);
      step(1'b0, 1'b1);
      bitslip = 1'b0;
      check("ce_low_dv", 16'(dv_b), 16'h0);
      check("ce_low_q0", 16'(q0_b), 16'h1);
      check("ce_low_q1", 16'(q1_b), 16'h0);
    end
    ce = 1'b1;
    for (int k = 42; k <= 48; k++) begin
      step(1'b1, 1'b0);
      check("ce_resume_dv", 16'(dv_b), 16'(k == 44 || k == 48));
      if (k == 44 || k == 48) check("ce_resume_word", 16'(dout_b), 16'hAA);
    end

    // Two cycles into a word, then an asynchronous clear with no clock edge.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("pre_clr_q0_a", 16'(q0_a), 16'h0);
    check("pre_clr_q1_a", 16'(q1_a), 16'h1);
    clr = 1'b1;
    #1;
    check("clr_q0_a",   16'(q0_a),   16'h1);
    check("clr_q1_a",   16'(q1_a),   16'h0);
    check("clr_q0_b",   16'(q0_b),   16'h0);
    check("clr_dout_b", 16'(dout_b), 16'h0);
    check("clr_dv_b",   16'(dv_b),   16'h0);
    step(1'b1, 1'b1);
    check("clr_hold_dout", 16'(dout_b), 16'h0);
    check("clr_hold_q0_a", 16'(q0_a),   16'h1);
    clr = 1'b0;
    for (int k = 52; k <= 59; k++) begin
      step(1'b1, 1'b1);
      check("rel_dv", 16'(dv_b), 16'(k == 55 || k == 59));
      if (k == 55) begin
        check("rel_first_b", 16'(dout_b), 16'h0F);
        check("rel_first_a", 16'(dout_a), 16'hAF);
      end
      if (k == 59) check("rel_second_a", 16'(dout_a), 16'hFF);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
